// File: rtl/mux_rr_arbiter_pkg.sv
// rtl/mux_rr_arbiter_pkg.sv - shared state encoding and source indices for the round-robin arbiter
package mux_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_e;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - two-producer / one-consumer handshake bundle around the arbiter
interface mux_rr_arbiter_if #(
    parameter int WIDTH = 1
) ();

    logic [1:0]       req;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic             dout_ready;
    logic [1:0]       gnt;
    logic             sel;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;

    modport master (
        output req, din0, din1, dout_ready,
        input  gnt, sel, dout, dout_valid
    );

    modport slave (
        input  req, din0, din1, dout_ready,
        output gnt, sel, dout, dout_valid
    );

endinterface

// File: rtl/mux_rr_arbiter_mux2_w.sv
// rtl/mux_rr_arbiter_mux2_w.sv - width-parameterized 2:1 data mux
module mux2_w #(
    parameter int WIDTH = 1
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - two-source round-robin arbiter with bounded grant hold driving one stream
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_rr_arbiter_if.slave       arb_io
);

    localparam int                HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic       cur_src;
    logic       own_req;
    logic       other_req;
    logic       xfer;
    arb_state_e other_state;

    assign arb_io.gnt        = {state_q == G1, state_q == G0};
    assign arb_io.sel        = (state_q == G1);
    assign arb_io.dout_valid = |(arb_io.gnt & arb_io.req);
    assign xfer              = arb_io.dout_valid & arb_io.dout_ready;

    assign cur_src     = (state_q == G1) ? SRC1 : SRC0;
    assign own_req     = arb_io.req[cur_src];
    assign other_req   = arb_io.req[~cur_src];
    assign other_state = (state_q == G1) ? G0 : G1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                // last_q==SRC1 means source 0 is owed the next tie
                if (arb_io.req[SRC0] && (!arb_io.req[SRC1] || last_q == SRC1)) begin
                    state_d = G0;
                end else if (arb_io.req[SRC1]) begin
                    state_d = G1;
                end
            end
            G0, G1: begin
                if (!own_req) begin
                    state_d = other_req ? other_state : IDLE;
                end else if (other_req &&
                             ((xfer && hold_q == HOLD_LAST) || hold_q == HOLD_MAX)) begin
                    state_d = other_state;
                end else if (xfer && hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            hold_d = '0;
            if (state_d == G0) begin
                last_d = SRC0;
            end else if (state_d == G1) begin
                last_d = SRC1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= SRC1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    mux2_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel_i (arb_io.sel),
        .d0_i  (arb_io.din0),
        .d1_i  (arb_io.din1),
        .y_o   (arb_io.dout)
    );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for the round-robin arbiter
module tb_mux_rr_arbiter;

    logic clk = 1'b0;
    logic rst;

    mux_rr_arbiter_if #(.WIDTH(8)) arb_if ();

    mux_rr_arbiter #(
        .WIDTH    (8),
        .MAX_HOLD (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_io (arb_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] sb_q[$];
    logic [8:0] sb_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push(input logic src, input logic [7:0] d, input int n);
        repeat (n) sb_q.push_back({src, d});
    endtask

    task automatic edge_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && arb_if.dout_valid && arb_if.dout_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_xfer", 32'({arb_if.sel, arb_if.dout}), 32'h1ff);
            end else begin
                sb_exp = sb_q.pop_front();
                check("sb_xfer", 32'({arb_if.sel, arb_if.dout}), 32'(sb_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        arb_if.req = 2'b11;
        arb_if.din0 = 8'h5a;
        arb_if.din1 = 8'ha5;
        arb_if.dout_ready = 1'b0;
        sample();
        check("rst_gnt", 32'(arb_if.gnt), 0);
        check("rst_sel", 32'(arb_if.sel), 0);
        check("rst_valid", 32'(arb_if.dout_valid), 0);
        check("rst_dout", 32'(arb_if.dout), 32'h5a);
        edge_drive(); rst = 1'b0; arb_if.req = 2'b00;
        sample();
        check("idle_gnt", 32'(arb_if.gnt), 0);

        // single source, six consecutive transfers
        edge_drive(); arb_if.req = 2'b01; arb_if.din0 = 8'h01; arb_if.dout_ready = 1'b1;
        push(1'b0, 8'h01, 6);
        sample();
        check("lat_gnt", 32'(arb_if.gnt), 0);
        check("lat_valid", 32'(arb_if.dout_valid), 0);
        for (int i = 0; i < 6; i++) begin
            edge_drive(); sample();
            check("single_gnt", 32'(arb_if.gnt), 1);
        end
        edge_drive(); arb_if.req = 2'b00; sample();
        check("single_drop_valid", 32'(arb_if.dout_valid), 0);
        edge_drive(); sample();
        check("single_idle_gnt", 32'(arb_if.gnt), 0);
        check("single_sb_empty", 32'(sb_q.size()), 0);

        // ties after idle: src0 last -> src1, then src1 last -> src0
        edge_drive(); arb_if.req = 2'b11; arb_if.dout_ready = 1'b0; sample();
        edge_drive(); sample();
        check("tie_after_src0_gnt", 32'(arb_if.gnt), 2);
        check("tie_after_src0_sel", 32'(arb_if.sel), 1);
        edge_drive(); arb_if.req = 2'b00; sample();
        edge_drive(); sample();
        check("tie_idle_gnt", 32'(arb_if.gnt), 0);
        edge_drive(); arb_if.req = 2'b11; arb_if.din0 = 8'h3c; arb_if.din1 = 8'hc3; sample();
        edge_drive(); sample();
        check("tie_after_src1_gnt", 32'(arb_if.gnt), 1);

        // back-pressure with competitor, then contention
        for (int i = 0; i < 4; i++) begin
            edge_drive(); sample();
            check("bp_gnt", 32'(arb_if.gnt), 1);
            check("bp_dout", 32'(arb_if.dout), 32'h3c);
        end
        edge_drive(); arb_if.dout_ready = 1'b1;
        push(1'b0, 8'h3c, 4); push(1'b1, 8'hc3, 4); push(1'b0, 8'h3c, 4);
        for (int i = 0; i < 12; i++) begin
            sample();
            check("cont_gnt", 32'(arb_if.gnt), (i < 4 || i >= 8) ? 1 : 2);
            check("cont_valid", 32'(arb_if.dout_valid), 1);
            edge_drive();
        end
        arb_if.req = 2'b00; arb_if.dout_ready = 1'b0; sample();
        check("cont_sb_empty", 32'(sb_q.size()), 0);
        edge_drive(); sample();
        check("cont_idle_gnt", 32'(arb_if.gnt), 0);

        // release handoff 01 -> 10
        edge_drive(); arb_if.req = 2'b01; arb_if.dout_ready = 1'b1;
        arb_if.din0 = 8'h11; arb_if.din1 = 8'h22; push(1'b0, 8'h11, 1); sample();
        edge_drive(); sample();
        check("ho_gnt0", 32'(arb_if.gnt), 1);
        edge_drive(); arb_if.req = 2'b10; sample();
        check("ho_release_valid", 32'(arb_if.dout_valid), 0);
        edge_drive(); arb_if.din1 = 8'h44; push(1'b1, 8'h44, 1); sample();
        check("ho_gnt1", 32'(arb_if.gnt), 2);
        check("ho_sel", 32'(arb_if.sel), 1);
        check("ho_dout", 32'(arb_if.dout), 32'h44);
        edge_drive(); arb_if.req = 2'b00; arb_if.dout_ready = 1'b0; sample();
        check("ho_sb_empty", 32'(sb_q.size()), 0);
        edge_drive(); sample();

        // reset mid-grant
        edge_drive(); arb_if.req = 2'b11; sample();
        edge_drive(); sample();
        check("pre_rst_gnt", 32'(arb_if.gnt), 1);
        rst = 1'b1; #1;
        check("mid_rst_gnt", 32'(arb_if.gnt), 0);
        check("mid_rst_sel", 32'(arb_if.sel), 0);
        check("mid_rst_valid", 32'(arb_if.dout_valid), 0);
        edge_drive(); rst = 1'b0; sample();
        check("post_rst_idle_gnt", 32'(arb_if.gnt), 0);
        edge_drive(); sample();
        check("post_rst_tie_gnt", 32'(arb_if.gnt), 1);

        // hold saturates without competitor, then switches without a transfer
        edge_drive(); arb_if.req = 2'b01; arb_if.dout_ready = 1'b1; arb_if.din0 = 8'h77;
        push(1'b0, 8'h77, 5);
        for (int i = 0; i < 5; i++) begin
            sample();
            check("sat_gnt", 32'(arb_if.gnt), 1);
            edge_drive();
        end
        arb_if.req = 2'b11; arb_if.dout_ready = 1'b0; sample();
        check("sat_hold_gnt", 32'(arb_if.gnt), 1);
        edge_drive(); sample();
        check("sat_switch_gnt", 32'(arb_if.gnt), 2);
        check("final_sb_empty", 32'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Two-requester round-robin arbiter that shares a single 2:1 select datapath between two sources and drives one output stream with a valid/ready handshake. It owns the mux select line, grants one requester at a time, and holds the grant for consecutive transfers. A bounded hold count stops either source from starving the other. It sits between two producers and a single consumer.

## Interface
- WIDTH, 1: data bits per input and output
- MAX_HOLD, 4: max consecutive transfers per grant while the other side is requesting; must be ≥1

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  2  req[k] high = source k has data on din_k
- din0  in  WIDTH  source 0 data
- din1  in  WIDTH  source 1 data
- dout_ready  in  1  consumer accepts dout this cycle
- gnt  out  2  one-hot grant, registered; gnt[k] & dout_ready = source k's data consumed
- sel  out  1  mux select, registered; 0 = din0, 1 = din1
- dout  out  WIDTH  selected data, combinational from sel
- dout_valid  out  1  (gnt[0]&req[0]) | (gnt[1]&req[1]), combinational

## Operation
- FSM states: IDLE, G0, G1. gnt = {state==G1, state==G0}; sel = (state==G1).
- Transfer: dout_valid & dout_ready.
- last pointer: records the most recently granted source; reset value 1, so source 0 wins the first tie.
- IDLE:
  - only one req high → grant it
  - both high → grant !last
  - none high → stay in IDLE
- Gk, req[k] low at edge:
  - req[other] high → G_other directly, no idle bubble
  - else → IDLE
- Gk, req[k] high:
  - hold_cnt counts transfers since the grant was taken.
  - It saturates at MAX_HOLD.
  - Switch to G_other at the edge where req[other] is high and either:
    - a transfer occurs with hold_cnt == MAX_HOLD-1, or
    - hold_cnt == MAX_HOLD already (no transfer needed).
  - Otherwise remain in Gk.
- hold_cnt clears on every grant change and on entry from IDLE.
- last updates on every entry into G0/G1.
- Data must not be consumed without a grant: dout_valid is 0 in IDLE.
- Width: hold_cnt is $clog2(MAX_HOLD+1) bits. MAX_HOLD=1 gives strict alternation under contention.

## Timing
- Reset values (async, immediate):
  - state IDLE, gnt 2'b00, sel 0, last 1, hold_cnt 0
  - dout_valid 0
  - dout = din0
- Arbitration latency: req asserted in IDLE → gnt on the next edge, so the first transfer is possible 1 cycle after req.
- Back-to-back switch costs 0 bubble cycles:
  - The final transfer of Gk happens in cycle n.
  - G_other is active in cycle n+1.
- Requester may drop req in the cycle after its last transfer. If req[k] is still high after its data was consumed, it is treated as new data.
- Simultaneous release and arrival (req[k] falls as req[other] rises) → G_other next edge.
- Consumer stall (dout_ready=0) with no competitor: grant held indefinitely, dout stable.
- Consumer stall with competitor and hold_cnt < MAX_HOLD: grant held; no forced switch until the limit is reached.
- Reset asserted mid-grant: grant drops immediately. After release the FSM restarts from IDLE with last=1.

## Structure
- Shared package: state enum (IDLE, G0, G1) and the grant-index constants SRC0=0, SRC1=1.
- One sub-module, mux2_w: WIDTH-parameterized 2:1 data mux driven by sel. It is reused by later multi-source blocks.
- Arbiter FSM, hold counter and last pointer live in mux_rr_arbiter.

## Test plan
- Reset: rst=1 mid-run with req=2'b11 → gnt=00, sel=0, dout_valid=0 within the same cycle. After release, req=11 → gnt=01 one cycle later.
- Single source: req=01, din0=1, dout_ready=1 for 6 cycles → gnt=01 from cycle 1, 6 transfers of dout=1, no switch. Then req=00 → IDLE next edge.
- Contention, MAX_HOLD=4, dout_ready=1, req=11 held → grant pattern 4 transfers src0, 4 transfers src1, 4 transfers src0. Zero bubble cycles at each switch.
- Back-pressure: req=11, dout_ready=0 for 5 cycles → gnt stays 01, hold_cnt stays 0, dout stable. Release ready → src0 still gets 4 transfers before the switch.
- Release handoff: G0 active, req goes 01→10 in one cycle → gnt=10 and sel=1 at the next edge, dout follows din1 in the same cycle.
- Tie after idle: src1 granted last, both sources then idle, then req=11 → gnt=01. Repeat with src0 granted last → gnt=10.
